// File: rtl/sync_fifo_param_pkg.sv
// rtl/sync_fifo_param_pkg.sv - shared widths and read-mode type for the single-clock FIFO
package sync_fifo_pkg;

   // Read-port behaviour selector, mirrors the FWFT parameter value
   typedef enum logic {
      STD  = 1'b0,
      FWFT = 1'b1
   } read_mode_e;

   // Pointer width: enough bits to index DEPTH entries, never less than one
   function automatic int ptr_w(input int depth);
      int w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

   // Occupancy width: must hold the value DEPTH itself
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - write/read handshake and status bundle of the single-clock FIFO
interface sync_fifo_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   import sync_fifo_pkg::*;

   localparam int CNT_W = cnt_w(DEPTH);

   logic             flush;
   logic             winc;
   logic [WIDTH-1:0] wdata;
   logic             wfull;
   logic             walmost_full;
   logic             rinc;
   logic [WIDTH-1:0] rdata;
   logic             rempty;
   logic             ralmost_empty;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             underflow;

   // Producer/consumer side that drives requests
   modport master (
      output flush, winc, wdata, rinc,
      input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
   );

   // FIFO side
   modport slave (
      input  flush, winc, wdata, rinc,
      output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/sync_fifo_param_ram.sv
// rtl/sync_fifo_param_ram.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read
module fifo_ram #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage is deliberately not reset; occupancy tracking makes stale entries invisible
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO controller with thresholds, sticky errors and FWFT
module sync_fifo_param #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = 14,
   parameter int AEMPTY_THRESH = 2,
   parameter int FWFT          = 0
) (
   input  logic             clk,
   input  logic             rst,
   sync_fifo_param_if.slave bus
);
   import sync_fifo_pkg::*;

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
   localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   // Parameter sanity, caught at elaboration
   if (DEPTH < 2) begin : g_chk_depth
      $error("sync_fifo_param: DEPTH must be at least 2");
   end
   if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_chk_afull
      $error("sync_fifo_param: AFULL_THRESH must lie in 1..DEPTH");
   end
   if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_chk_aempty
      $error("sync_fifo_param: AEMPTY_THRESH must lie in 0..DEPTH-1");
   end

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wfull_q, wfull_d;
   logic             rempty_q, rempty_d;
   logic             afull_q, afull_d;
   logic             aempty_q, aempty_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             wr_acc;
   logic             rd_acc;
   logic             ram_we;
   logic [WIDTH-1:0] ram_rdata;

   // Wrapping increment; the explicit wrap at DEPTH-1 allows non-power-of-two depths
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Acceptance decisions are based on the registered flags only
   assign wr_acc = bus.winc && !wfull_q;
   assign rd_acc = bus.rinc && !rempty_q;
   assign ram_we = wr_acc && !bus.flush && !rst;

   // Next-state: pointers, occupancy, sticky errors, then flags derived from the next count
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      if (bus.flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
      end else begin
         if (wr_acc) begin
            wptr_d = ptr_next(wptr_q);
         end
         if (rd_acc) begin
            rptr_d = ptr_next(rptr_q);
         end
         count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
         ovf_d   = ovf_q | (bus.winc & wfull_q);
         udf_d   = udf_q | (bus.rinc & rempty_q);
      end
      wfull_d  = (count_d == DEPTH_C);
      rempty_d = (count_d == '0);
      afull_d  = (count_d >= AFULL_C);
      aempty_d = (count_d <= AEMPTY_C);
   end

   // State register; reset values match an empty FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         wfull_q  <= 1'b0;
         rempty_q <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         wfull_q  <= wfull_d;
         rempty_q <= rempty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   fifo_ram #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (wptr_q),
      .wdata_i (bus.wdata),
      .raddr_i (rptr_q),
      .rdata_o (ram_rdata)
   );

   if (FWFT == 0) begin : g_std
      logic [WIDTH-1:0] rdata_q;

      // Registered read: capture the head entry on an accepted pop, otherwise hold
      always_ff @(posedge clk) begin
         if (rst) begin
            rdata_q <= '0;
         end else if (rd_acc && !bus.flush) begin
            rdata_q <= ram_rdata;
         end
      end

      assign bus.rdata = rdata_q;

      a_rdata_known: assert property (@(posedge clk) disable iff (rst)
         (rd_acc && !bus.flush) |=> !$isunknown(rdata_q));
   end else begin : g_fwft
      // Head entry is presented directly; rinc acts as the acknowledge
      assign bus.rdata = ram_rdata;
   end

   assign bus.wfull         = wfull_q;
   assign bus.rempty        = rempty_q;
   assign bus.walmost_full  = afull_q;
   assign bus.ralmost_empty = aempty_q;
   assign bus.count         = count_q;
   assign bus.overflow      = ovf_q;
   assign bus.underflow     = udf_q;

   a_not_full_and_empty: assert property (@(posedge clk) disable iff (rst)
      !(wfull_q && rempty_q));
   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count_q <= DEPTH_C);
   a_wptr_bound: assert property (@(posedge clk) disable iff (rst)
      32'(wptr_q) < DEPTH);
   a_rptr_bound: assert property (@(posedge clk) disable iff (rst)
      32'(rptr_q) < DEPTH);

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param in registered and FWFT modes
module tb_sync_fifo_param;
   import sync_fifo_pkg::*;

   localparam int DA     = 6;
   localparam int AF_A   = 4;
   localparam int AE_A   = 1;
   localparam int DB     = 4;
   localparam read_mode_e MODE_A = STD;
   localparam read_mode_e MODE_B = FWFT;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   sync_fifo_param_if #(.WIDTH(8), .DEPTH(DA)) bus_a ();
   sync_fifo_param_if #(.WIDTH(8), .DEPTH(DB)) bus_b ();

   sync_fifo_param #(
      .WIDTH(8), .DEPTH(DA), .AFULL_THRESH(AF_A), .AEMPTY_THRESH(AE_A), .FWFT(int'(MODE_A))
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   sync_fifo_param #(
      .WIDTH(8), .DEPTH(DB), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(int'(MODE_B))
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] sb_a[$];
   logic [7:0] sb_b[$];
   logic [7:0] m_rd  = 8'h00;
   logic       m_ovf = 1'b0;
   logic       m_udf = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Compare every observable output of FIFO A against the reference model
   task automatic check_a();
      int c;
      c = sb_a.size();
      check("a.count",         32'(bus_a.count),   32'(c));
      check("a.wfull",         32'(bus_a.wfull),   32'(c == DA));
      check("a.rempty",        32'(bus_a.rempty),  32'(c == 0));
      check("a.walmost_full",  32'(bus_a.walmost_full),  32'(c >= AF_A));
      check("a.ralmost_empty", 32'(bus_a.ralmost_empty), 32'(c <= AE_A));
      check("a.overflow",      32'(bus_a.overflow),  32'(m_ovf));
      check("a.underflow",     32'(bus_a.underflow), 32'(m_udf));
      check("a.rdata",         32'(bus_a.rdata),     32'(m_rd));
   endtask

   // One clock on FIFO A: drive, advance the model across the edge, then compare
   task automatic cyc_a(input bit w, input logic [7:0] d, input bit r, input bit fl, input bit rs);
      bit full, empty;
      bus_a.winc  = w;
      bus_a.wdata = d;
      bus_a.rinc  = r;
      bus_a.flush = fl;
      rst         = rs;
      @(posedge clk);
      full  = (sb_a.size() == DA);
      empty = (sb_a.size() == 0);
      if (rs || fl) begin
         sb_a.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         if (rs) m_rd = 8'h00;
      end else begin
         if (w && full)  m_ovf = 1'b1;
         if (r && empty) m_udf = 1'b1;
         if (r && !empty) m_rd = sb_a.pop_front();
         if (w && !full) sb_a.push_back(d);
      end
      #1;
      check_a();
   endtask

   // One clock on FIFO B with a small queue model; FWFT shows the head before any pop
   task automatic cyc_b(input bit w, input logic [7:0] d, input bit r);
      bus_b.winc  = w;
      bus_b.wdata = d;
      bus_b.rinc  = r;
      @(posedge clk);
      if (r && sb_b.size() != 0) void'(sb_b.pop_front());
      if (w && sb_b.size() != DB) sb_b.push_back(d);
      #1;
      bus_b.winc = 1'b0;
      bus_b.rinc = 1'b0;
      check("b.rempty", 32'(bus_b.rempty), 32'(sb_b.size() == 0));
      check("b.count",  32'(bus_b.count),  32'(sb_b.size()));
      if (sb_b.size() != 0) check("b.rdata_head", 32'(bus_b.rdata), 32'(sb_b[0]));
   endtask

   initial begin
      bus_a.winc = 1'b0; bus_a.rinc = 1'b0; bus_a.flush = 1'b0; bus_a.wdata = '0;
      bus_b.winc = 1'b0; bus_b.rinc = 1'b0; bus_b.flush = 1'b0; bus_b.wdata = '0;

      // Reset state
      cyc_a(0, 8'h00, 0, 0, 1);
      cyc_a(0, 8'h00, 0, 0, 1);
      check("b.reset_rempty", 32'(bus_b.rempty), 32'd1);

      // Fill 0x11..0x66, then an overflowing write of 0x77
      for (int i = 1; i <= DA; i++) cyc_a(1, 8'(i * 17), 0, 0, 0);
      cyc_a(1, 8'h77, 0, 0, 0);
      check("a.full_after_overflow", 32'(bus_a.count), 32'd6);

      // Drain, data order checked by the scoreboard
      repeat (DA) cyc_a(0, 8'h00, 1, 0, 0);

      // Batches of four crossing the 5->0 wrap
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 4; i++) cyc_a(1, 8'(8'h80 + k * 4 + i), 0, 0, 0);
         repeat (4) cyc_a(0, 8'h00, 1, 0, 0);
      end

      // Empty with simultaneous write and read
      cyc_a(0, 8'h00, 0, 1, 0);
      cyc_a(1, 8'hA5, 1, 0, 0);
      cyc_a(0, 8'h00, 1, 0, 0);
      check("a.empty_rw_data", 32'(bus_a.rdata), 32'hA5);

      // Steady state at count 3 with simultaneous traffic
      cyc_a(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < 3; i++) cyc_a(1, 8'(8'hC0 + i), 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc_a(1, 8'(8'hD0 + i), 1, 0, 0);

      // Reach count 5 with overflow set, then flush alongside a write
      for (int i = 0; i < 3; i++) cyc_a(1, 8'(8'hE0 + i), 0, 0, 0);
      cyc_a(1, 8'hEE, 0, 0, 0);
      cyc_a(0, 8'h00, 1, 0, 0);
      cyc_a(1, 8'hF0, 0, 1, 0);
      check("a.flush_count", 32'(bus_a.count), 32'd0);

      // Same again, cleared by reset instead
      for (int i = 0; i < 6; i++) cyc_a(1, 8'(8'h30 + i), 0, 0, 0);
      cyc_a(1, 8'h3F, 0, 0, 0);
      cyc_a(0, 8'h00, 1, 0, 0);
      cyc_a(1, 8'hF1, 0, 0, 1);
      cyc_a(0, 8'h00, 0, 0, 0);
      rst = 1'b0;

      // FWFT: data visible the cycle after the write, before any pop
      cyc_b(1, 8'h3C, 0);
      check("b.fwft_rdata", 32'(bus_b.rdata), 32'h3C);
      cyc_b(0, 8'h00, 1);
      check("b.fwft_pop_empty", 32'(bus_b.rempty), 32'd1);
      cyc_b(1, 8'h5A, 0);
      cyc_b(1, 8'h6B, 0);
      cyc_b(0, 8'h00, 1);
      cyc_b(1, 8'h7C, 1);
      cyc_b(0, 8'h00, 1);
      cyc_b(0, 8'h00, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, fully parametrised FIFO; next-generation sibling of the dual-clock FIFO, used where producer and consumer share one clock.
- Generalises width and depth; depth need not be a power of two.
- Adds almost-full/almost-empty thresholds, occupancy count, sticky overflow/underflow flags, synchronous flush, and a first-word-fall-through (FWFT) read mode.
- Keeps the winc/rinc/wfull/rempty handshake of the dual-clock FIFO.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 16, number of entries (>=2, any integer)
AFULL_THRESH, 14, walmost_full asserts when count >= this (1..DEPTH)
AEMPTY_THRESH, 2, ralmost_empty asserts when count <= this (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of contents and error flags
winc  input  1  write request
wdata  input  WIDTH  write data
wfull  output  1  FIFO full
walmost_full  output  1  count >= AFULL_THRESH
rinc  input  1  read request (pop)
rdata  output  WIDTH  read data
rempty  output  1  FIFO empty
ralmost_empty  output  1  count <= AEMPTY_THRESH
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. No asynchronous logic.
- Reset values: wptr=rptr=0, count=0, rempty=1, wfull=0, walmost_full=0, ralmost_empty=1, overflow=0, underflow=0, rdata=0. Storage array is not reset.
- Priority: rst > flush > normal operation.
- Flush: pointers, count and flags return to their reset values. Accesses in the flush cycle are ignored and do not set error flags. rdata holds its value.
- Write accepted iff winc && !wfull; stores wdata at wptr.
- Read accepted iff rinc && !rempty; advances rptr.
- Full with winc && rinc in the same cycle: read accepted, write rejected, overflow set.
- Empty with winc && rinc in the same cycle: write accepted, read rejected, underflow set.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. Comparison is count-based, so non-power-of-two depth is legal.
- Count: next count = count + wr_acc - rd_acc. Both accepted in one cycle leaves count unchanged. Count never exceeds DEPTH and never underflows.
- Flags: wfull = (count==DEPTH), rempty = (count==0), walmost_full and ralmost_empty as defined in Ports.
  - All flags are registered, computed from next count, so they reflect post-edge state.
  - Write into an empty FIFO: rempty falls on that same edge, so the data is readable the following cycle.
- Sticky errors: overflow sets on winc && wfull; underflow sets on rinc && rempty. Both clear only on rst or flush.
- FWFT=0: rdata is registered. On an accepted read, rdata takes mem[rptr] at that edge (1-cycle latency). Otherwise rdata holds.
- FWFT=1: rdata = mem[rptr] continuously while !rempty; rinc acknowledges and pops. rdata is don't-care while rempty.
- Elaboration checks ($error):
  - DEPTH < 2
  - AFULL_THRESH outside 1..DEPTH
  - AEMPTY_THRESH outside 0..DEPTH-1
- Embedded assertions (disabled while rst):
  - never wfull && rempty
  - count <= DEPTH
  - rdata not X on the cycle after an accepted read (FWFT=0)
  - wptr and rptr stay < DEPTH

Decomposition:
- Package sync_fifo_pkg:
  - function ptr_w(depth) returning $clog2(depth), min 1
  - function cnt_w(depth) returning $clog2(depth+1)
  - enum read_mode_e {STD, FWFT} for bench configuration
- Sub-module fifo_ram:
  - DEPTH x WIDTH, one synchronous write port and one asynchronous read port
  - FWFT=0 registers its output in the parent; FWFT=1 uses it directly
- Controller logic stays in sync_fifo_param.

Test Plan:
- Config WIDTH=8, DEPTH=6, AFULL=4, AEMPTY=1, FWFT=0. Reset, then write 0x11..0x66 on 6 consecutive cycles -> count 1..6; walmost_full rises on the edge count=4; wfull=1 after the 6th write; rempty=0 after the 1st write.
- From full, winc with wdata=0x77 -> overflow=1, count stays 6. Then read 6 times -> rdata 0x11..0x66, each one cycle after rinc. Repeat writes and reads crossing index 5->0 -> data order preserved across the wrap.
- Empty FIFO, winc=1 (0xA5) and rinc=1 in the same cycle -> count=1, underflow=1, rempty=0. Next cycle rinc -> rdata=0xA5, rempty=1.
- Count=3, winc and rinc together for 10 cycles with incrementing data -> count stays 3, output sequence exact, no error flags.
- Count=5 with overflow=1, then flush=1 alongside winc=1 -> count=0, rempty=1, overflow=0, write discarded. Repeat with rst instead of flush -> all outputs at reset values, including rdata=0.
- FWFT=1: write 0x3C -> the next cycle shows rempty=0 and rdata=0x3C before any rinc. rinc pops -> rempty=1 the following cycle.
